uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter between NREQ byte requesters using round-robin

---
 rtl/uart_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte requesters.
// Sequences grant -> start pulse -> wait for done/timeout and keeps sticky status flags.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 20000,
  parameter int CW      = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [NREQ-1:0]   flag_done,
  output logic [NREQ-1:0]   flag_err,
  input  logic [NREQ-1:0]   flag_clr,
  output logic              sched_busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            tx_start_q, tx_start_d;
  logic [NREQ-1:0] flag_done_q, flag_done_d;
  logic [NREQ-1:0] flag_err_q, flag_err_d;
  logic [NREQ-1:0] set_done, set_err;

  // Round-robin pick: lowest valid index above last_grant, else lowest valid index.
  logic            hi_found, lo_found, pick_found;
  logic [GW-1:0]   hi_idx, lo_idx, pick_idx;
  logic [7:0]      hi_data, lo_data, pick_data;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    hi_found = 1'b0;
    hi_idx   = '0;
    hi_data  = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    lo_data  = '0;
    // Descending scan so the last hit written is the lowest qualifying index.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = GW'(i);
        lo_data  = req_data[8*i +: 8];
        if (GW'(i) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
          hi_data  = req_data[8*i +: 8];
        end
      end
    end
    pick_found = hi_found | lo_found;
    pick_idx   = hi_found ? hi_idx  : lo_idx;
    pick_data  = hi_found ? hi_data : lo_data;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    req_ready_d  = '0;
    tx_start_d   = 1'b0;
    set_done     = '0;
    set_err      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!tx_busy && pick_found) begin
          tx_data_d   = pick_data;
          grant_d     = pick_idx;
          state_d     = S_START;
          // Registered pulses line up with the START cycle itself.
          tx_start_d  = 1'b1;
          req_ready_d = ONE << pick_idx;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (tx_done) begin
          set_done     = ONE << grant_q;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          set_err      = ONE << grant_q;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A set on the same cycle beats a host clear of the same bit.
    flag_done_d = (flag_done_q & ~flag_clr) | set_done;
    flag_err_d  = (flag_err_q  & ~flag_clr) | set_err;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NREQ - 1);
      cnt_q        <= '0;
      tx_data_q    <= '0;
      req_ready_q  <= '0;
      tx_start_q   <= 1'b0;
      flag_done_q  <= '0;
      flag_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      req_ready_q  <= req_ready_d;
      tx_start_q   <= tx_start_d;
      flag_done_q  <= flag_done_d;
      flag_err_q   <= flag_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign flag_done  = flag_done_q;
  assign flag_err   = flag_err_q;
  assign sched_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (NREQ=4, TIMEOUT=16).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [3:0]  flag_done;
  logic [3:0]  flag_err;
  logic [3:0]  flag_clr = '0;
  logic        sched_busy;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_scheduler #(.NREQ(4), .TIMEOUT(16), .CW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .flag_done  (flag_done),
    .flag_err   (flag_err),
    .flag_clr   (flag_clr),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    flag_clr  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({req_ready, tx_start, tx_data, flag_done, flag_err, sched_busy} !== 22'h0) begin
      $display("FAIL reset_outputs: got %h expected %h",
               {req_ready, tx_start, tx_data, flag_done, flag_err, sched_busy}, 22'h0);
      miscompares++;
    end
  endtask

  task automatic test_single();
    req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
    req_valid = 4'b0001;
    step();
    vectors++;
    if ({tx_start, req_ready, tx_data, sched_busy} !== {1'b1, 4'b0001, 8'hA5, 1'b1}) begin
      $display("FAIL single_start: got %h expected %h",
               {tx_start, req_ready, tx_data, sched_busy}, {1'b1, 4'b0001, 8'hA5, 1'b1});
      miscompares++;
    end
    req_valid = '0;
    step();
    vectors++;
    if ({tx_start, req_ready, tx_data} !== {1'b0, 4'b0000, 8'hA5}) begin
      $display("FAIL single_wait: got %h expected %h",
               {tx_start, req_ready, tx_data}, {1'b0, 4'b0000, 8'hA5});
      miscompares++;
    end
    repeat (8) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if ({flag_done, flag_err, sched_busy} !== {4'b0001, 4'b0000, 1'b0}) begin
      $display("FAIL single_done: got %h expected %h",
               {flag_done, flag_err, sched_busy}, {4'b0001, 4'b0000, 1'b0});
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_r;
    logic [7:0] exp_d;
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_r = 4'b0001 << order[n];
      exp_d = 8'((order[n] + 1) * 17);
      step();
      vectors++;
      if ({tx_start, req_ready, tx_data} !== {1'b1, exp_r, exp_d}) begin
        $display("FAIL rr_grant%0d: got %h expected %h", n,
                 {tx_start, req_ready, tx_data}, {1'b1, exp_r, exp_d});
        miscompares++;
      end
      step();
      vectors++;
      if ({tx_start, req_ready} !== 5'b0) begin
        $display("FAIL rr_pulse_width%0d: got %h expected %h", n, {tx_start, req_ready}, 5'b0);
        miscompares++;
      end
      repeat (3) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      if (n == 4) req_valid = '0;
      vectors++;
      if ({flag_done[order[n]], sched_busy} !== 2'b10) begin
        $display("FAIL rr_done%0d: got %b expected %b", n, {flag_done[order[n]], sched_busy}, 2'b10);
        miscompares++;
      end
    end
    vectors++;
    if (flag_done !== 4'b1111) begin
      $display("FAIL rr_all_flags: got %b expected %b", flag_done, 4'b1111);
      miscompares++;
    end
  endtask

  task automatic test_busy();
    do_reset();
    tx_busy   = 1'b1;
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({tx_start, sched_busy} !== 2'b00) begin
        $display("FAIL busy_hold%0d: got %b expected %b", i, {tx_start, sched_busy}, 2'b00);
        miscompares++;
      end
    end
    tx_busy = 1'b0;
    step();
    vectors++;
    if ({tx_start, req_ready} !== {1'b1, 4'b0010}) begin
      $display("FAIL busy_release: got %h expected %h", {tx_start, req_ready}, {1'b1, 4'b0010});
      miscompares++;
    end
    req_valid = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if (flag_done !== 4'b0010) begin
      $display("FAIL busy_done: got %b expected %b", flag_done, 4'b0010);
      miscompares++;
    end
    // A requester that withdraws while the UART is busy is never served.
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    tx_busy   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({tx_start, sched_busy} !== 2'b00) begin
        $display("FAIL busy_withdraw%0d: got %b expected %b", i, {tx_start, sched_busy}, 2'b00);
        miscompares++;
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    for (int i = 1; i < 16; i++) begin
      step();
      vectors++;
      if ({flag_err, sched_busy} !== {4'b0000, 1'b1}) begin
        $display("FAIL timeout_early%0d: got %h expected %h", i, {flag_err, sched_busy}, {4'b0000, 1'b1});
        miscompares++;
      end
    end
    step();
    vectors++;
    if ({flag_err, flag_done, sched_busy} !== {4'b0100, 4'b0000, 1'b0}) begin
      $display("FAIL timeout_flag: got %h expected %h",
               {flag_err, flag_done, sched_busy}, {4'b0100, 4'b0000, 1'b0});
      miscompares++;
    end
  endtask

  task automatic test_done_priority();
    req_valid = 4'b0001;
    step();
    vectors++;
    if ({tx_start, req_ready} !== {1'b1, 4'b0001}) begin
      $display("FAIL prio_grant: got %h expected %h", {tx_start, req_ready}, {1'b1, 4'b0001});
      miscompares++;
    end
    req_valid = '0;
    tx_done   = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if ({flag_done, sched_busy} !== {4'b0000, 1'b1}) begin
      $display("FAIL start_done_ignored: got %h expected %h", {flag_done, sched_busy}, {4'b0000, 1'b1});
      miscompares++;
    end
    repeat (15) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if ({flag_done, flag_err, sched_busy} !== {4'b0001, 4'b0100, 1'b0}) begin
      $display("FAIL prio_done_on_timeout: got %h expected %h",
               {flag_done, flag_err, sched_busy}, {4'b0001, 4'b0100, 1'b0});
      miscompares++;
    end
  endtask

  task automatic test_flag_clr();
    req_valid = 4'b0010;
    step();
    vectors++;
    if (req_ready !== 4'b0010) begin
      $display("FAIL clr_grant: got %b expected %b", req_ready, 4'b0010);
      miscompares++;
    end
    req_valid = '0;
    step();
    tx_done  = 1'b1;
    flag_clr = 4'b0111;
    step();
    tx_done  = 1'b0;
    flag_clr = '0;
    vectors++;
    if ({flag_done, flag_err} !== {4'b0010, 4'b0000}) begin
      $display("FAIL clr_set_wins: got %h expected %h", {flag_done, flag_err}, {4'b0010, 4'b0000});
      miscompares++;
    end
    flag_clr = 4'b0010;
    step();
    flag_clr = '0;
    vectors++;
    if (flag_done !== 4'b0000) begin
      $display("FAIL clr_alone: got %b expected %b", flag_done, 4'b0000);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    step();
    vectors++;
    if (req_ready !== 4'b0100) begin
      $display("FAIL mid_grant: got %b expected %b", req_ready, 4'b0100);
      miscompares++;
    end
    req_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({req_ready, tx_start, tx_data, flag_done, flag_err, sched_busy} !== 22'h0) begin
      $display("FAIL mid_reset_outputs: got %h expected %h",
               {req_ready, tx_start, tx_data, flag_done, flag_err, sched_busy}, 22'h0);
      miscompares++;
    end
    req_valid = 4'b1111;
    step();
    vectors++;
    if ({tx_start, req_ready} !== {1'b1, 4'b0001}) begin
      $display("FAIL mid_next_grant: got %h expected %h", {tx_start, req_ready}, {1'b1, 4'b0001});
      miscompares++;
    end
    req_valid = '0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    vectors++;
    if (flag_done !== 4'b0001) begin
      $display("FAIL mid_done: got %b expected %b", flag_done, 4'b0001);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_timeout();
    test_done_priority();
    test_flag_clr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
